// File: rtl/bcd_modn_counter.sv
// ---------------------------------------------------------------------------
// bcd_modn_counter
//   Multi-digit BCD modulo-N up/down counter for the clock datapath
//   (seconds/minutes mod 60, hours mod 24, ...). Stages are cascaded by
//   feeding one stage's TC into the next stage's EN.
//
// Parameters
//   DIGITS  : number of BCD digits (1..4)
//   MODULUS : count modulus in decimal (2..10^DIGITS), count is 0..MODULUS-1
//   INIT    : reset value in decimal (< MODULUS)
//
// Ports
//   CP   in   clock, rising edge
//   nCR  in   asynchronous active-low clear, forces Q to INIT
//   EN   in   count enable
//   UP   in   1 = increment, 0 = decrement
//   LD   in   synchronous load strobe (wins over EN)
//   D    in   BCD load value, ones digit in [3:0]
//   Q    out  registered BCD count, ones digit in [3:0]
//   TC   out  combinational terminal count / carry for cascading
//   ERR  out  registered one-cycle pulse when a load value is rejected
// ---------------------------------------------------------------------------
module bcd_modn_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60,
  parameter int INIT    = 0
) (
  input  logic                  CP,
  input  logic                  nCR,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LD,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic                  ERR
);

  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Decimal to BCD, used only on elaboration-time constants.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD  = to_bcd(MODULUS - 1);
  localparam logic [W-1:0] INIT_BCD = to_bcd(INIT);

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("bcd_modn_counter: DIGITS must be 1..4");
  end
  if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_modn_counter: MODULUS must be 2..10^DIGITS");
  end
  if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
    $error("bcd_modn_counter: INIT must be less than MODULUS");
  end

  function automatic logic digits_legal(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // With every digit 0..9, BCD ordering equals plain unsigned ordering of the
  // bit vector, so the range test is a direct compare against MAX_BCD.
  function automatic logic in_range(input logic [W-1:0] v);
    return digits_legal(v) && (v <= MAX_BCD);
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] q_q, q_d;
  logic         err_q, err_d;

  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (LD) begin
      if (in_range(D)) q_d = D;
      else             err_d = 1'b1;
    end else if (EN) begin
      // A corrupted state is steered back to a legal end of the range.
      if (!in_range(q_q)) begin
        q_d = UP ? '0 : MAX_BCD;
      end else if (UP) begin
        q_d = (q_q == MAX_BCD) ? '0 : bcd_inc(q_q);
      end else begin
        q_d = (q_q == '0) ? MAX_BCD : bcd_dec(q_q);
      end
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      q_q   <= INIT_BCD;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign Q   = q_q;
  assign ERR = err_q;
  // Combinational so a downstream stage enabled by TC advances on this edge.
  assign TC  = EN & ~LD & ((UP & (q_q == MAX_BCD)) | (~UP & (q_q == '0)));

endmodule

// File: tb/tb_bcd_modn_counter.sv
module tb_bcd_modn_counter;

  logic cp  = 1'b0;
  logic ncr = 1'b1;

  logic       en_a = 1'b0, up_a = 1'b0, ld_a = 1'b0;
  logic [7:0] d_a  = 8'h00;
  logic [7:0] q_a;
  logic       tc_a, err_a;

  logic       en_b = 1'b0, up_b = 1'b0, ld_b = 1'b0, casc = 1'b0;
  logic [7:0] d_b  = 8'h00;
  logic [7:0] q_b;
  logic       tc_b, err_b, en_b_eff;

  logic       en_c = 1'b0, up_c = 1'b0, ld_c = 1'b0;
  logic [3:0] d_c  = 4'h0;
  logic [3:0] q_c;
  logic       tc_c, err_c;

  assign en_b_eff = casc ? tc_a : en_b;

  bcd_modn_counter #(.DIGITS(2), .MODULUS(60), .INIT(0)) u_a (
    .CP(cp), .nCR(ncr), .EN(en_a), .UP(up_a), .LD(ld_a), .D(d_a),
    .Q(q_a), .TC(tc_a), .ERR(err_a));

  bcd_modn_counter #(.DIGITS(2), .MODULUS(24), .INIT(0)) u_b (
    .CP(cp), .nCR(ncr), .EN(en_b_eff), .UP(up_b), .LD(ld_b), .D(d_b),
    .Q(q_b), .TC(tc_b), .ERR(err_b));

  bcd_modn_counter #(.DIGITS(1), .MODULUS(6), .INIT(0)) u_c (
    .CP(cp), .nCR(ncr), .EN(en_c), .UP(up_c), .LD(ld_c), .D(d_c),
    .Q(q_c), .TC(tc_c), .ERR(err_c));

  always #5 cp = ~cp;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (plain decimal integers) ------------
  int m_a = 0, m_b = 0, m_c = 0;
  int e_a = 0, e_b = 0, e_c = 0;

  function automatic int bcd_val(input logic [15:0] b, input int nd);
    int v;
    v = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return -1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  function automatic logic [31:0] dec2bcd(input int v);
    logic [31:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] tcm(input int v, input int md, input logic en,
                                      input logic up, input logic ld);
    return {31'b0, en && !ld && ((up && v == md - 1) || (!up && v == 0))};
  endfunction

  task automatic step(inout int v, inout int e, input int md, input int nd,
                      input logic en, input logic up, input logic ld,
                      input logic [15:0] d);
    int dv;
    e = 0;
    if (ld) begin
      dv = bcd_val(d, nd);
      if (dv >= 0 && dv < md) v = dv;
      else                    e = 1;
    end else if (en) begin
      v = up ? (v + 1) % md : (v + md - 1) % md;
    end
  endtask

  always @(posedge cp or negedge ncr) begin
    logic ta;
    if (!ncr) begin
      m_a = 0; m_b = 0; m_c = 0;
      e_a = 0; e_b = 0; e_c = 0;
    end else begin
      ta = tcm(m_a, 60, en_a, up_a, ld_a) != 0;
      step(m_a, e_a, 60, 2, en_a, up_a, ld_a, {8'h00, d_a});
      step(m_b, e_b, 24, 2, casc ? ta : en_b, up_b, ld_b, {8'h00, d_b});
      step(m_c, e_c, 6, 1, en_c, up_c, ld_c, {12'h000, d_c});
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge cp) begin
    logic eb;
    eb = casc ? (tcm(m_a, 60, en_a, up_a, ld_a) != 0) : en_b;
    chk("q_a",   {24'h0, q_a},   dec2bcd(m_a));
    chk("tc_a",  {31'h0, tc_a},  tcm(m_a, 60, en_a, up_a, ld_a));
    chk("err_a", {31'h0, err_a}, e_a);
    chk("q_b",   {24'h0, q_b},   dec2bcd(m_b));
    chk("tc_b",  {31'h0, tc_b},  tcm(m_b, 24, eb, up_b, ld_b));
    chk("err_b", {31'h0, err_b}, e_b);
    chk("q_c",   {28'h0, q_c},   dec2bcd(m_c));
    chk("tc_c",  {31'h0, tc_c},  tcm(m_c, 6, en_c, up_c, ld_c));
    chk("err_c", {31'h0, err_c}, e_c);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge cp);
      #2;
    end
  endtask

  // ---------------- directed stimulus with literal expectations -----------
  initial begin
    #1 ncr = 1'b0;
    tick(2);
    chk("rst_q_a",   {24'h0, q_a},   32'h00);
    chk("rst_err_a", {31'h0, err_a}, 32'h0);
    chk("rst_q_c",   {28'h0, q_c},   32'h0);
    ncr = 1'b1;

    // mod 60 up-count, mod 6 up-count in parallel
    en_a = 1'b1; up_a = 1'b1; en_c = 1'b1; up_c = 1'b1;
    tick(5);
    chk("c_at5",    {28'h0, q_c},  32'h5);
    chk("c_tc_at5", {31'h0, tc_c}, 32'h1);
    tick(1);
    chk("c_wrap",   {28'h0, q_c},  32'h0);
    en_c = 1'b0;
    tick(53);
    chk("a_at59",    {24'h0, q_a},  32'h59);
    chk("a_tc_at59", {31'h0, tc_a}, 32'h1);
    tick(1);
    chk("a_wrap",    {24'h0, q_a},  32'h00);
    chk("a_tc_at00", {31'h0, tc_a}, 32'h0);
    tick(1);
    chk("a_at01",    {24'h0, q_a},  32'h01);
    en_a = 1'b0;

    // mod 24 down-count with borrow across digits
    en_b = 1'b1; up_b = 1'b0;
    #1 chk("b_tc_at00", {31'h0, tc_b}, 32'h1);
    tick(1);
    chk("b_at23", {24'h0, q_b}, 32'h23);
    tick(13);
    chk("b_at10", {24'h0, q_b}, 32'h10);
    tick(1);
    chk("b_at09", {24'h0, q_b}, 32'h09);
    en_b = 1'b0;

    // loads, including rejected values
    ld_a = 1'b1; d_a = 8'h45; en_a = 1'b1; up_a = 1'b1;
    tick(1);
    chk("ld45_q",   {24'h0, q_a},   32'h45);
    chk("ld45_err", {31'h0, err_a}, 32'h0);
    d_a = 8'h60;
    tick(1);
    chk("ld60_q",   {24'h0, q_a},   32'h45);
    chk("ld60_err", {31'h0, err_a}, 32'h1);
    ld_a = 1'b0; en_a = 1'b0;
    tick(1);
    chk("err_pulse_end", {31'h0, err_a}, 32'h0);
    ld_a = 1'b1; d_a = 8'h3A;
    tick(1);
    chk("ld3a_q",   {24'h0, q_a},   32'h45);
    chk("ld3a_err", {31'h0, err_a}, 32'h1);
    ld_a = 1'b0;
    tick(1);

    // cascade 59/23 -> 00/00 on one edge
    ld_a = 1'b1; d_a = 8'h59; ld_b = 1'b1; d_b = 8'h23;
    tick(1);
    ld_a = 1'b0; ld_b = 1'b0; casc = 1'b1; en_a = 1'b1; up_a = 1'b1; up_b = 1'b1;
    #1;
    chk("casc_tc_a", {31'h0, tc_a}, 32'h1);
    chk("casc_tc_b", {31'h0, tc_b}, 32'h1);
    tick(1);
    chk("casc_q_a", {24'h0, q_a}, 32'h00);
    chk("casc_q_b", {24'h0, q_b}, 32'h00);

    // EN low on the first stage freezes both
    en_a = 1'b0; ld_a = 1'b1; d_a = 8'h59; ld_b = 1'b1; d_b = 8'h05;
    tick(1);
    ld_a = 1'b0; ld_b = 1'b0;
    tick(3);
    chk("frz_q_a", {24'h0, q_a}, 32'h59);
    chk("frz_q_b", {24'h0, q_b}, 32'h05);
    en_a = 1'b1;
    tick(1);
    chk("unfrz_q_a", {24'h0, q_a}, 32'h00);
    chk("unfrz_q_b", {24'h0, q_b}, 32'h06);
    en_a = 1'b0; casc = 1'b0;

    // asynchronous clear mid-count
    ld_a = 1'b1; d_a = 8'h36;
    tick(1);
    ld_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
    tick(1);
    chk("pre_clr_q", {24'h0, q_a}, 32'h37);
    #2 ncr = 1'b0;
    #1 chk("async_clr_q", {24'h0, q_a}, 32'h00);
    tick(3);
    chk("held_clr_q", {24'h0, q_a}, 32'h00);
    ncr = 1'b1;
    tick(1);
    chk("resume_01", {24'h0, q_a}, 32'h01);
    tick(1);
    chk("resume_02", {24'h0, q_a}, 32'h02);

    en_a = 1'b0;
    tick(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_modn_counter.md
Name: bcd_modn_counter

Overview:
- Parametrised multi-digit BCD modulo-N counter for the clock datapath, e.g. seconds/minutes (mod 60) and hours (mod 24).
- Counts up or down with wrap-around.
- Supports synchronous preset for time setting and checks preset values for range.
- Provides a combinational terminal-count output so stages can be cascaded into a full clock chain.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1..4.
- MODULUS, 60, count modulus in decimal; legal range 2..10^DIGITS; count range is 0..MODULUS-1.
- INIT, 0, reset value in decimal; must be less than MODULUS.

Ports:
- CP  input  1  clock, rising-edge active.
- nCR  input  1  asynchronous active-low clear; forces the counter to INIT.
- EN  input  1  count enable; count advances only when high.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LD  input  1  synchronous load strobe.
- D  input  4*DIGITS  BCD load value; digit 0 (ones) in bits [3:0].
- Q  output  4*DIGITS  BCD count, registered; digit 0 in bits [3:0].
- TC  output  1  terminal count/carry, combinational.
- ERR  output  1  load-rejected flag, registered, one-cycle pulse.

Behaviour:
- Reset (nCR=0): asynchronous, takes effect immediately regardless of CP.
  - Q = BCD(INIT), ERR = 0.
  - Q holds at that value while nCR is low.
  - Release is synchronous in effect: the first update happens on the first CP rising edge after nCR goes high.
- Priority on each CP rising edge (nCR=1): LD > EN > hold.
- Load (LD=1):
  - D is accepted only if every digit is 0..9 and its decimal value is less than MODULUS. Then Q <= D and ERR <= 0.
  - Otherwise Q holds and ERR <= 1 for exactly one cycle.
  - LD overrides EN and UP; no counting occurs in a load cycle.
- Count (LD=0, EN=1):
  - UP=1: Q <= Q+1 in BCD.
    - Each digit carries 9 -> 0 into the next digit.
    - At Q = MODULUS-1, Q <= 0.
  - UP=0: Q <= Q-1 in BCD.
    - Each digit borrows 0 -> 9 from the next digit.
    - At Q = 0, Q <= MODULUS-1.
  - ERR <= 0.
- Hold (LD=0, EN=0): Q unchanged, ERR <= 0.
- TC = EN & ~LD & ((UP & Q==MODULUS-1) | (~UP & Q==0)).
  - Purely combinational, with no registered delay.
  - The next stage's EN is driven from this stage's TC; cascaded stages advance on the same edge.
- Direction change: takes effect on the next enabled edge; no state is retained between directions.
- Out-of-range state: Q should never be out of range, since load is guarded.
  - Defensive rule: if Q holds an illegal BCD digit or a value >= MODULUS, the next enabled count forces Q to 0 for UP=1 and to MODULUS-1 for UP=0.
- Width rules:
  - Q and D are exactly 4*DIGITS bits.
  - Comparisons against MODULUS-1 use that constant converted to BCD at elaboration time.
  - No binary intermediate wider than needed.
- Parameter check: an elaboration-time error is raised if MODULUS > 10^DIGITS, MODULUS < 2, or INIT >= MODULUS.

Test Plan:
- DIGITS=2, MODULUS=60: reset, then EN=1, UP=1 for 61 edges -> Q steps 00..59 then 00. TC=1 only while Q=59; Q never shows a hex digit A-F.
- DIGITS=2, MODULUS=24, UP=0 from Q=00 -> next edge Q=23 with TC=1 at Q=00. Then continue 23, 22 ... 10, 09, checking the borrow across the digit boundary.
- LD=1 with D=8'h45 (MODULUS=60) and EN=1 -> Q=45, ERR=0, no increment that cycle. Then LD with D=8'h60 -> Q stays 45 and ERR=1 for one cycle. Then LD with D=8'h3A -> Q stays 45 and ERR=1.
- Cascade two instances (mod 60, then mod 24 with EN fed by the first stage's TC) from 59/23 -> a single edge gives 00/00. Also check that EN=0 on the first stage freezes both stages.
- Assert nCR low mid-count, away from a CP edge, with Q=37 and INIT=0 -> Q=00 immediately, with no clock edge needed. Hold nCR low across edges -> Q stays 00. Release nCR -> counting resumes 01, 02 on subsequent edges.
- DIGITS=1, MODULUS=6, INIT=0 -> count sequence 0..5, 0, with TC at 5.
